// File: rtl/rewind_walker_pkg.sv
// Shared types for the rename-history rewind walker: history entry layout,
// walk FSM states and default geometry.
`ifndef WAY
`define WAY 2
`endif

package rewind_walker_pkg;

   localparam int unsigned PHY_REG_W  = 6;
   localparam int unsigned HIST_DEPTH = 32;

   typedef logic [PHY_REG_W-1:0] phy_reg_idx_t;

   typedef struct packed {
      phy_reg_idx_t T;
      phy_reg_idx_t Told;
      logic         wr;
   } hist_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      WALK = 1'b1
   } walk_state_t;

endpackage

// File: rtl/rewind_walker_compact.sv
// Packs the selected, dest-writing entries of one popped group into lanes
// 0..m-1 (input order preserved) and reports m; unused lanes read zero.
module rewind_compact
   import rewind_walker_pkg::*;
#(
   parameter int WAY = `WAY
) (
   input  hist_entry_t  [WAY-1:0]      ent_i,
   input  logic         [WAY-1:0]      vld_i,
   output phy_reg_idx_t [WAY-1:0]      t_o,
   output phy_reg_idx_t [WAY-1:0]      told_o,
   output logic [$clog2(WAY+1)-1:0]    num_o
);

   localparam int CW = $clog2(WAY+1);

   logic [WAY-1:0] sel;
   int             pre [WAY];
   int             total;

   always_comb begin
      total = 0;
      for (int i = 0; i < WAY; i++) begin
         sel[i] = vld_i[i] & ent_i[i].wr;
         pre[i] = total;
         total  = total + (sel[i] ? 1 : 0);
      end
   end

   // Each output lane takes the selected entry whose prefix count equals its index.
   always_comb begin
      t_o    = '0;
      told_o = '0;
      for (int j = 0; j < WAY; j++) begin
         for (int i = 0; i < WAY; i++) begin
            if (sel[i] && pre[i] == j) begin
               t_o[j]    = ent_i[i].T;
               told_o[j] = ent_i[i].Told;
            end
         end
      end
      num_o = CW'(total);
   end

endmodule

// File: rtl/rewind_walker.sv
// Rename-history buffer with squash walk: records {T, Told, wr} per renamed
// instruction and, on mispredict, replays the youngest entries as rewind groups.
module rewind_walker #(
   parameter int WAY        = `WAY,
   parameter int HIST_DEPTH = rewind_walker_pkg::HIST_DEPTH
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic [$clog2(WAY+1)-1:0]                      dispatch_num,
   input  rewind_walker_pkg::phy_reg_idx_t [WAY-1:0]     dispatch_T,
   input  rewind_walker_pkg::phy_reg_idx_t [WAY-1:0]     dispatch_Told,
   input  logic [WAY-1:0]                                dispatch_wr,
   input  logic [$clog2(WAY+1)-1:0]                      retire_num,
   input  logic                                          squash_valid,
   input  logic [$clog2(HIST_DEPTH+1)-1:0]               squash_count,
   output logic [$clog2(WAY+1)-1:0]                      rewind_num,
   output rewind_walker_pkg::phy_reg_idx_t [WAY-1:0]     rewind_T,
   output rewind_walker_pkg::phy_reg_idx_t [WAY-1:0]     rewind_Told,
   output logic                                          busy,
   output logic [$clog2(HIST_DEPTH+1)-1:0]               space_avail
);

   import rewind_walker_pkg::*;

   localparam int PW = $clog2(HIST_DEPTH);
   localparam int CW = $clog2(WAY+1);

   // Pointer = index plus wrap bit; the same width also holds any occupancy.
   typedef logic [PW:0] ptr_t;

   walk_state_t            state_q, state_d;
   ptr_t                   head_q, head_d, tail_q, tail_d;
   ptr_t                   rem_q, rem_d, space_q, space_d;
   logic [CW-1:0]          rewind_num_q, rewind_num_d;
   phy_reg_idx_t [WAY-1:0] rewind_T_q, rewind_T_d, rewind_Told_q, rewind_Told_d;

   hist_entry_t            hist_q [HIST_DEPTH];
   hist_entry_t [WAY-1:0]  pop_ent;
   logic [WAY-1:0]         pop_vld;
   phy_reg_idx_t [WAY-1:0] cmp_T, cmp_Told;
   logic [CW-1:0]          cmp_num;

   ptr_t                   occ, retire_eff, disp_eff, sq_c, walk_k;
   logic [CW-1:0]          push_n;

   assign occ = tail_q - head_q;

   // Protocol violations are clamped so the pointers never cross each other.
   always_comb begin
      retire_eff = ptr_t'(retire_num);
      if (retire_eff > occ - rem_q) retire_eff = occ - rem_q;
      disp_eff = ptr_t'(dispatch_num);
      if (disp_eff > space_q) disp_eff = space_q;
      sq_c = ptr_t'(squash_count);
      if (sq_c > occ - retire_eff) sq_c = occ - retire_eff;
      walk_k = (rem_q < ptr_t'(WAY)) ? rem_q : ptr_t'(WAY);
   end

   always_comb begin
      for (int i = 0; i < WAY; i++) begin
         pop_ent[i] = hist_q[tail_q[PW-1:0] - PW'(i + 1)];
         pop_vld[i] = (ptr_t'(i) < walk_k);
      end
   end

   rewind_compact #(.WAY(WAY)) u_compact (
      .ent_i  (pop_ent),
      .vld_i  (pop_vld),
      .t_o    (cmp_T),
      .told_o (cmp_Told),
      .num_o  (cmp_num)
   );

   always_comb begin
      state_d = state_q;
      head_d  = head_q + retire_eff;
      tail_d  = tail_q;
      rem_d   = rem_q;
      push_n  = '0;
      case (state_q)
         IDLE: begin
            if (squash_valid) begin
               if (sq_c != '0) begin
                  rem_d   = sq_c;
                  state_d = WALK;
               end
            end else begin
               push_n = CW'(disp_eff);
               tail_d = tail_q + disp_eff;
            end
         end
         WALK: begin
            tail_d = tail_q - walk_k;
            rem_d  = rem_q - walk_k;
            if (rem_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      space_d = ptr_t'(HIST_DEPTH) - (tail_d - head_d);

      rewind_num_d  = '0;
      rewind_T_d    = '0;
      rewind_Told_d = '0;
      if (state_q == WALK) begin
         rewind_num_d  = cmp_num;
         rewind_T_d    = cmp_T;
         rewind_Told_d = cmp_Told;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         head_q        <= '0;
         tail_q        <= '0;
         rem_q         <= '0;
         space_q       <= ptr_t'(HIST_DEPTH);
         rewind_num_q  <= '0;
         rewind_T_q    <= '0;
         rewind_Told_q <= '0;
      end else begin
         state_q       <= state_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         rem_q         <= rem_d;
         space_q       <= space_d;
         rewind_num_q  <= rewind_num_d;
         rewind_T_q    <= rewind_T_d;
         rewind_Told_q <= rewind_Told_d;
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < WAY; i++) begin
         if (ptr_t'(i) < ptr_t'(push_n)) begin
            hist_q[tail_q[PW-1:0] + PW'(i)] <= '{T: dispatch_T[i], Told: dispatch_Told[i], wr: dispatch_wr[i]};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && state_q == IDLE && !squash_valid)
         assert (ptr_t'(dispatch_num) <= space_q);
      if (!reset)
         assert (ptr_t'(retire_num) <= occ - rem_q);
   end

   assign rewind_num  = rewind_num_q;
   assign rewind_T    = rewind_T_q;
   assign rewind_Told = rewind_Told_q;
   assign busy        = (state_q == WALK);
   assign space_avail = space_q;

endmodule

// File: tb/tb_rewind_walker.sv
// Bench for rewind_walker (WAY=2, HIST_DEPTH=8): directed scenarios plus random
// traffic, every cycle compared against a queue-based model of the history.
module tb_rewind_walker;
   import rewind_walker_pkg::*;

   localparam int WAY = 2;
   localparam int HD  = 8;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic [1:0]             dispatch_num = '0;
   phy_reg_idx_t [WAY-1:0] dispatch_T = '0;
   phy_reg_idx_t [WAY-1:0] dispatch_Told = '0;
   logic [WAY-1:0]         dispatch_wr = '0;
   logic [1:0]             retire_num = '0;
   logic                   squash_valid = 1'b0;
   logic [3:0]             squash_count = '0;
   logic [1:0]             rewind_num;
   phy_reg_idx_t [WAY-1:0] rewind_T, rewind_Told;
   logic                   busy;
   logic [3:0]             space_avail;

   rewind_walker #(.WAY(WAY), .HIST_DEPTH(HD)) dut (
      .clock        (clock),
      .reset        (reset),
      .dispatch_num (dispatch_num),
      .dispatch_T   (dispatch_T),
      .dispatch_Told(dispatch_Told),
      .dispatch_wr  (dispatch_wr),
      .retire_num   (retire_num),
      .squash_valid (squash_valid),
      .squash_count (squash_count),
      .rewind_num   (rewind_num),
      .rewind_T     (rewind_T),
      .rewind_Told  (rewind_Told),
      .busy         (busy),
      .space_avail  (space_avail)
   );

   always #5 clock = ~clock;

   typedef struct {
      int t;
      int told;
      bit wr;
   } ment_t;

   ment_t mq[$];
   bit    m_walk;
   int    m_rem;
   int    e_num;
   int    e_t[WAY];
   int    e_told[WAY];
   int    checks = 0;
   int    errors = 0;

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Behavioural model: oldest entry at the front, youngest at the back.
   task automatic model_step();
      ment_t e;
      e_num = 0;
      for (int l = 0; l < WAY; l++) begin
         e_t[l]    = 0;
         e_told[l] = 0;
      end
      if (reset) begin
         mq.delete();
         m_walk = 0;
         m_rem  = 0;
         return;
      end
      for (int r = 0; r < int'(retire_num); r++) void'(mq.pop_front());
      if (m_walk) begin
         int k;
         k = imin(WAY, m_rem);
         for (int j = 0; j < k; j++) begin
            e = mq.pop_back();
            if (e.wr) begin
               e_t[e_num]    = e.t;
               e_told[e_num] = e.told;
               e_num++;
            end
         end
         m_rem -= k;
         if (m_rem == 0) m_walk = 0;
      end else if (squash_valid) begin
         int c;
         c = imin(int'(squash_count), mq.size());
         if (c > 0) begin
            m_walk = 1;
            m_rem  = c;
         end
      end else begin
         for (int l = 0; l < int'(dispatch_num); l++) begin
            e.t    = int'(dispatch_T[l]);
            e.told = int'(dispatch_Told[l]);
            e.wr   = dispatch_wr[l];
            mq.push_back(e);
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clock);
      #1;
      chk("rewind_num", 32'(rewind_num), e_num);
      for (int l = 0; l < WAY; l++) begin
         chk($sformatf("rewind_T[%0d]", l), 32'(rewind_T[l]), e_t[l]);
         chk($sformatf("rewind_Told[%0d]", l), 32'(rewind_Told[l]), e_told[l]);
      end
      chk("busy", 32'(busy), 32'(m_walk));
      chk("space_avail", 32'(space_avail), HD - mq.size());
   endtask

   task automatic quiet();
      dispatch_num = '0;
      dispatch_wr  = '0;
      retire_num   = '0;
      squash_valid = 1'b0;
      squash_count = '0;
   endtask

   task automatic lane(int l, int t, int told, bit wr);
      dispatch_T[l]    = phy_reg_idx_t'(t);
      dispatch_Told[l] = phy_reg_idx_t'(told);
      dispatch_wr[l]   = wr;
   endtask

   initial begin
      m_walk = 0;
      m_rem  = 0;
      quiet();

      // Reset and idle
      step();
      step();
      reset = 1'b0;
      step();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_space", 32'(space_avail), 8);

      // Three writing entries, squash all three
      dispatch_num = 2; lane(0, 33, 3, 1); lane(1, 34, 4, 1); step();
      dispatch_num = 1; lane(0, 35, 33, 1); step();
      quiet(); squash_valid = 1'b1; squash_count = 3; step();
      chk("sq3_busy0", 32'(busy), 1);
      quiet(); step();
      chk("sq3_g1_num", 32'(rewind_num), 2);
      chk("sq3_g1_T0", 32'(rewind_T[0]), 35);
      chk("sq3_g1_Told0", 32'(rewind_Told[0]), 33);
      chk("sq3_g1_T1", 32'(rewind_T[1]), 34);
      chk("sq3_g1_Told1", 32'(rewind_Told[1]), 4);
      step();
      chk("sq3_g2_num", 32'(rewind_num), 1);
      chk("sq3_g2_T0", 32'(rewind_T[0]), 33);
      chk("sq3_g2_Told0", 32'(rewind_Told[0]), 3);
      chk("sq3_done_busy", 32'(busy), 0);
      chk("sq3_space", 32'(space_avail), 8);
      step();

      // No-op entry in the middle is never emitted
      dispatch_num = 2; lane(0, 40, 1, 1); lane(1, 41, 2, 0); step();
      dispatch_num = 1; lane(0, 42, 3, 1); step();
      quiet(); squash_valid = 1'b1; squash_count = 3; step();
      quiet(); step();
      chk("noop_g1_num", 32'(rewind_num), 1);
      chk("noop_g1_T0", 32'(rewind_T[0]), 42);
      chk("noop_g1_T1", 32'(rewind_T[1]), 0);
      step();
      chk("noop_g2_num", 32'(rewind_num), 1);
      chk("noop_g2_T0", 32'(rewind_T[0]), 40);
      step();

      // Fill, wrap the pointers, then squash everything across the wrap
      for (int c = 0; c < 4; c++) begin
         dispatch_num = 2; lane(0, 10 + 2*c, 2*c, 1); lane(1, 11 + 2*c, 2*c + 1, 1); step();
      end
      chk("full_space", 32'(space_avail), 0);
      quiet(); retire_num = 2; step();
      quiet(); dispatch_num = 2; lane(0, 18, 8, 1); lane(1, 19, 9, 1); step();
      quiet(); squash_valid = 1'b1; squash_count = 8; step();
      quiet();
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("wrap_busy%0d", g), 32'(busy), 1);
         step();
         chk($sformatf("wrap_g%0d_T0", g), 32'(rewind_T[0]), 19 - 2*g);
         chk($sformatf("wrap_g%0d_T1", g), 32'(rewind_T[1]), 18 - 2*g);
      end
      chk("wrap_done_busy", 32'(busy), 0);
      step();

      // Squash, dispatch and retire in the same cycle
      dispatch_num = 2; lane(0, 50, 1, 1); lane(1, 51, 2, 1); step();
      dispatch_num = 2; lane(0, 52, 3, 1); lane(1, 53, 4, 1); step();
      quiet(); squash_valid = 1'b1; squash_count = 2; retire_num = 1;
      dispatch_num = 2; lane(0, 60, 5, 1); lane(1, 61, 6, 1); step();
      quiet(); step();
      chk("mix_num", 32'(rewind_num), 2);
      chk("mix_T0", 32'(rewind_T[0]), 53);
      chk("mix_T1", 32'(rewind_T[1]), 52);
      chk("mix_space", 32'(space_avail), 7);
      retire_num = 1; step();
      quiet(); step();

      // Reset in the second walk cycle aborts the walk
      dispatch_num = 2; lane(0, 20, 1, 1); lane(1, 21, 2, 1); step();
      dispatch_num = 1; lane(0, 22, 3, 1); step();
      quiet(); squash_valid = 1'b1; squash_count = 3; step();
      quiet(); step();
      chk("rst_g1_num", 32'(rewind_num), 2);
      reset = 1'b1; step();
      chk("rst_num", 32'(rewind_num), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_space", 32'(space_avail), 8);
      reset = 1'b0; step();
      chk("rst_after_num", 32'(rewind_num), 0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         int room;
         int live;
         quiet();
         live = mq.size() - m_rem;
         retire_num = 2'($urandom_range(0, imin(2, live)));
         if ($urandom_range(0, 7) == 0) begin
            squash_valid = 1'b1;
            squash_count = 4'($urandom_range(0, 10));
         end
         room = HD - mq.size();
         if (m_walk || squash_valid)
            dispatch_num = 2'($urandom_range(0, 2));
         else
            dispatch_num = 2'($urandom_range(0, imin(2, room)));
         for (int l = 0; l < WAY; l++)
            lane(l, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), bit'($urandom_range(0, 1)));
         step();
      end
      quiet();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rewind_walker.md
REWIND_WALKER -- requirements
Module: rewind_walker

Interface
REQ-001 The block SHALL take parameters, one per line (name, default, meaning):
- WAY, `WAY: superscalar width.
- HIST_DEPTH, 32: rename-history entries, power of two.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- dispatch_num, in, $clog2(WAY+1): renamed instructions this cycle, lanes 0..n-1, oldest first.
- dispatch_T, in, WAY x phy_reg_idx_t: new physical dest per lane.
- dispatch_Told, in, WAY x phy_reg_idx_t: previous mapping per lane.
- dispatch_wr, in, WAY: lane wrote a nonzero arch dest.
- retire_num, in, $clog2(WAY+1): oldest entries committed this cycle.
- squash_valid, in, 1: mispredict recovery request.
- squash_count, in, $clog2(HIST_DEPTH+1): number of youngest entries to undo.
- rewind_num, out, $clog2(WAY+1): valid rewind lanes; drives map_table/free-list rewind.num.
- rewind_T, out, WAY x phy_reg_idx_t: mapping to undo; drives rewind.reg_T.
- rewind_Told, out, WAY x phy_reg_idx_t: mapping to restore; drives rewind.reg_Told.
- busy, out, 1: walk in progress; upstream stalls dispatch.
- space_avail, out, $clog2(HIST_DEPTH+1): free history entries.

Function
REQ-003 The history SHALL be a circular buffer with head and tail pointers, each carrying a wrap bit; occupancy is tail minus head, and full/empty are distinguished by the wrap bit.
REQ-004 In IDLE without squash_valid, the block SHALL push dispatch_num entries {T, Told, wr} at the tail in lane order; it SHALL push entries with wr=0 as no-op entries.
REQ-005 The block SHALL pop retire_num entries from the head every cycle, in any state.
REQ-006 The FSM SHALL have states IDLE and WALK; busy=1 exactly while in WALK.
REQ-007 In IDLE, squash_valid with clamped count C>0 SHALL load remaining=C and move the FSM to WALK next cycle; C = min(squash_count, occupancy after that cycle's retire); C=0 SHALL leave the FSM in IDLE.
REQ-008 Dispatch inputs in the squash cycle SHALL be discarded.
REQ-009 Each WALK cycle SHALL pop k = min(WAY, remaining) entries from the tail, youngest first; the FSM SHALL return to IDLE when remaining reaches 0.
REQ-010 Of the k popped entries, only those with wr=1 SHALL be emitted, compacted into lanes 0..m-1 in youngest-first order; rewind_num = m, which may be 0.
REQ-011 Rewind outputs SHALL be registered: the group popped in WALK cycle t is visible in cycle t+1; the first group appears 2 cycles after squash_valid; total walk takes ceil(C/WAY) cycles.
REQ-012 Outside valid lanes, and whenever no group is being presented, rewind_num, rewind_T and rewind_Told SHALL be 0.
REQ-013 In WALK, squash_valid and dispatch inputs SHALL be ignored; retire SHALL still be applied.
REQ-014 space_avail SHALL equal HIST_DEPTH minus occupancy, registered.
REQ-015 dispatch_num > space_avail and retire_num > (occupancy − remaining) are protocol violations; both SHALL be flagged by assertions, and the pointers SHALL NOT be corrupted beyond wrap.

Reset
REQ-016 On reset the block SHALL set head=tail=0 with wrap bits 0, FSM=IDLE, remaining=0, busy=0, rewind_num=0, rewind_T=0, rewind_Told=0, space_avail=HIST_DEPTH.
REQ-017 Reset SHALL abort an in-progress walk, with no further rewind output.

Structure
REQ-018 The shared rewind package SHALL hold the hist_entry_t typedef {T, Told, wr}, the walk_state_t enum {IDLE, WALK}, and the HIST_DEPTH constant.
REQ-019 Lane packing SHALL live in the combinational sub-module rewind_compact: WAY entries plus a valid mask in, a prefix-sum-compacted lane vector and count out.

Verification (WAY=2, HIST_DEPTH=8)
REQ-020 Reset, then idle -> busy=0, rewind_num=0, space_avail=8.
REQ-021 Dispatch {T=33,Told=3,wr},{T=34,Told=4,wr}, then {T=35,Told=33,wr}; squash_count=3 -> lane pairs (35,33),(34,4) two cycles after squash, then (33,3) next cycle; busy high 2 cycles; space_avail returns to 8.
REQ-022 Entries with wr pattern 1,0,1 (T=40,_,42), squash 3 -> rewind_num 1 (T=42), then rewind_num 1 (T=40); the no-op entry is never emitted.
REQ-023 Fill 8 entries, wrap the pointers via retire 2 plus dispatch 2, then squash 8 -> clamped to occupancy, 4 walk cycles, correct youngest-first order across the wrap.
REQ-024 Same-cycle squash_count=2, dispatch_num=2, retire_num=1 with occupancy 4 -> dispatch dropped, 1 head entry retired, 2 tail entries rewound, final occupancy 1.
REQ-025 Assert reset during the second walk cycle -> outputs 0 the next cycle and FSM=IDLE.
